// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port 32-word data memory between the core load/store
//   port (cpu_*) and a debug/loader port (dbg_*). At most one access is
//   granted per cycle. The CPU wins conflicts unless the debug port has
//   already lost STARVE_LIMIT consecutive cycles. A registered lock gives
//   the debug port exclusive ownership of the memory.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata       CPU access request and payload
//   cpu_gnt, cpu_stall          CPU accepted this cycle / CPU must wait
//   cpu_rvalid, cpu_rdata       CPU load data, one cycle after its grant
//   dbg_req/we/addr/wdata       debug access request and payload
//   dbg_gnt                     debug accepted this cycle
//   dbg_rvalid, dbg_rdata       debug load data, one cycle after its grant
//   dbg_lock, dbg_locked        exclusive-ownership request / lock active
//   mem_en/we/addr/wdata        memory command (all zero when idle)
//   mem_rdata                   memory read data, cycle after a read
//   state_dbg, wait_cnt_dbg     arbiter state and starvation count
//
// Handshake: a requester raises *_req with a stable-or-changing payload and
//   keeps it high until *_gnt is seen in the same cycle. The payload is only
//   sampled in the grant cycle, so changing address/we while stalled is legal.
//   A granted load returns *_rvalid with *_rdata exactly one cycle later.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic              dbg_locked,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg,
    output logic [CNT_W-1:0]  wait_cnt_dbg
);

    // State records the owner of the previous cycle; LOCK means the debug
    // port holds exclusive ownership for the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DBG  = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              lock_q;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              cpu_rv_q, dbg_rv_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lock_q   <= 1'b0;
            wait_q   <= '0;
            cpu_rv_q <= 1'b0;
            dbg_rv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= dbg_lock;
            wait_q   <= wait_d;
            cpu_rv_q <= cpu_gnt & ~cpu_we;
            dbg_rv_q <= dbg_gnt & ~dbg_we;
        end
    end

    // ---------------- arbitration / next state ----------------
    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        state_d   = ST_IDLE;
        wait_d    = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Grants are forced low while reset is asserted so that a request
        // held across reset never reaches the memory.
        if (rst_n) begin
            if (state_q == ST_LOCK) begin
                dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
                // Starved debug port takes exactly one conflicting cycle.
                if (wait_q == CNT_W'(STARVE_LIMIT)) dbg_gnt = 1'b1;
                else                                cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end

        if (dbg_lock)     state_d = ST_LOCK;
        else if (cpu_gnt) state_d = ST_CPU;
        else if (dbg_gnt) state_d = ST_DBG;
        else              state_d = ST_IDLE;

        // Counts consecutive lost cycles; any grant or dropped request clears it.
        if (dbg_req && !dbg_gnt) begin
            if (wait_q == CNT_W'(STARVE_LIMIT)) wait_d = wait_q;
            else                                wait_d = wait_q + CNT_W'(1);
        end

        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // ---------------- outputs ----------------
    assign cpu_stall    = cpu_req & ~cpu_gnt;
    assign cpu_rvalid   = cpu_rv_q;
    assign dbg_rvalid   = dbg_rv_q;
    assign cpu_rdata    = cpu_rv_q ? mem_rdata : '0;
    assign dbg_rdata    = dbg_rv_q ? mem_rdata : '0;
    assign dbg_locked   = lock_q;
    assign state_dbg    = state_q;
    assign wait_cnt_dbg = wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Drives dmem_arbiter with directed scenarios and random traffic. A small
//   memory behind the arbiter serves mem_* commands; a behavioural model
//   (grant rules, starvation count, lock, reference memory and per-port
//   expected-load queues) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int LIMIT = 3;

    logic        clk, rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [4:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, dbg_locked;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  state_dbg;
    logic [1:0]  wait_cnt_dbg;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock), .dbg_locked(dbg_locked),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory behind the arbiter ----------------
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [32];
    logic [31:0] exp_cpu_q[$];
    logic [31:0] exp_dbg_q[$];
    int          m_wait, m_state;
    bit          m_lock, m_cpu_pend, m_dbg_pend;

    // observations from the most recent step
    bit          obs_cgnt, obs_dgnt, obs_stall, obs_locked, obs_crv, obs_drv;
    logic [31:0] obs_drdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_state = 0; m_lock = 0;
        m_cpu_pend = 0; m_dbg_pend = 0;
        exp_cpu_q.delete();
        exp_dbg_q.delete();
    endtask

    // Applies reset with the current inputs still driven, checks the quiet
    // outputs, then releases. Called just after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #4;
        check("rst_cpu_gnt",  cpu_gnt, 0);
        check("rst_dbg_gnt",  dbg_gnt, 0);
        check("rst_cpu_rv",   cpu_rvalid, 0);
        check("rst_dbg_rv",   dbg_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_mem_en",   mem_en, 0);
        check("rst_mem_we",   mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_locked",   dbg_locked, 0);
        check("rst_state",    state_dbg, 0);
        check("rst_wait",     wait_cnt_dbg, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, advance.
    task automatic step(input bit creq, input bit cwe, input logic [4:0] caddr,
                        input logic [31:0] cwd, input bit dreq, input bit dwe,
                        input logic [4:0] daddr, input logic [31:0] dwd, input bit dlock);
        bit          ec, ed;
        logic [31:0] ecd, edd;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
        dbg_lock = dlock;
        #4;
        if (m_lock) begin
            ec = 0; ed = dreq;
        end else if (creq && dreq) begin
            ed = (m_wait == LIMIT); ec = !ed;
        end else begin
            ec = creq; ed = dreq;
        end
        check("cpu_gnt",   cpu_gnt, ec);
        check("dbg_gnt",   dbg_gnt, ed);
        check("cpu_stall", cpu_stall, creq && !ec);
        check("dbg_locked", dbg_locked, m_lock);
        check("mem_en",    mem_en, ec || ed);
        check("mem_we",    mem_we, ec ? cwe : (ed ? dwe : 0));
        check("mem_addr",  mem_addr, ec ? caddr : (ed ? daddr : 0));
        check("mem_wdata", mem_wdata, ec ? cwd : (ed ? dwd : 0));
        check("cpu_rvalid", cpu_rvalid, m_cpu_pend);
        check("dbg_rvalid", dbg_rvalid, m_dbg_pend);
        ecd = 0; edd = 0;
        if (m_cpu_pend && exp_cpu_q.size() > 0) ecd = exp_cpu_q.pop_front();
        if (m_dbg_pend && exp_dbg_q.size() > 0) edd = exp_dbg_q.pop_front();
        check("cpu_rdata", cpu_rdata, ecd);
        check("dbg_rdata", dbg_rdata, edd);
        check("state",     state_dbg, m_state);
        check("wait_cnt",  wait_cnt_dbg, m_wait);
        obs_cgnt = cpu_gnt; obs_dgnt = dbg_gnt; obs_stall = cpu_stall;
        obs_locked = dbg_locked; obs_crv = cpu_rvalid; obs_drv = dbg_rvalid;
        obs_drdata = dbg_rdata;

        if (ec && !cwe) exp_cpu_q.push_back(ref_mem[caddr]);
        if (ed && !dwe) exp_dbg_q.push_back(ref_mem[daddr]);
        if (ec && cwe) ref_mem[caddr] = cwd;
        if (ed && dwe) ref_mem[daddr] = dwd;
        m_cpu_pend = ec && !cwe;
        m_dbg_pend = ed && !dwe;
        m_wait  = (dreq && !ed) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
        m_lock  = dlock;
        m_state = dlock ? 3 : (ec ? 1 : (ed ? 2 : 0));
        @(posedge clk); #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    bit [5:0] gnt_seq, stall_seq;
    bit       rlock;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem_rdata = '0;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
        @(posedge clk); #1;
        do_reset();

        // CPU only: store then load at address 5
        step(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step(1, 0, 5'd5, 32'h0, 0, 0, 0, 0, 0);
        idle_step();
        check("t2_cpu_rvalid", obs_crv, 1);

        // Reset in the middle of a granted load: rvalid must never appear
        step(1, 0, 5'd7, 32'h0, 0, 0, 0, 0, 0);
        check("t1_gnt_before_rst", obs_cgnt, 1);
        do_reset();
        cpu_req = 0;
        idle_step();
        check("t1_no_rvalid", obs_crv, 0);
        idle_step();

        // Conflict held 6 cycles: C,C,C,D,C,C
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 5'(i), 0, 1, 0, 5'(31 - i), 0, 0);
            gnt_seq[5 - i]   = obs_cgnt;
            stall_seq[5 - i] = obs_stall;
        end
        idle_step();
        check("t3_grant_seq", gnt_seq, 6'b111011);
        check("t3_stall_seq", stall_seq, 6'b000100);

        // Lock while CPU keeps requesting
        idle_step();
        step(1, 0, 5'd1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 5'd2, 0, 0, 0, 0, 0, 1);
        check("t4_gnt_lock_edge", obs_cgnt, 1);
        step(1, 0, 5'd2, 0, 1, 1, 5'd9, 32'hA5A5A5A5, 1);
        check("t4_gnt_locked", obs_cgnt, 0);
        check("t4_locked", obs_locked, 1);
        check("t4_dbg_in_lock", obs_dgnt, 1);
        step(1, 0, 5'd2, 0, 0, 0, 0, 0, 0);
        check("t4_still_locked", obs_cgnt, 0);
        step(1, 0, 5'd2, 0, 0, 0, 0, 0, 0);
        check("t4_regrant", obs_cgnt, 1);
        idle_step();

        // DBG load from the top address
        step(0, 0, 0, 0, 1, 1, 5'd31, 32'h12345678, 0);
        step(0, 0, 0, 0, 1, 0, 5'd31, 0, 0);
        idle_step();
        check("t5_dbg_rvalid", obs_drv, 1);
        check("t5_dbg_rdata", obs_drdata, 32'h12345678);
        check("t5_cpu_rvalid", obs_crv, 0);

        // Idle stretch
        for (int i = 0; i < 10; i++) idle_step();
        check("t6_state_idle", state_dbg, 0);
        check("t6_wait_zero", wait_cnt_dbg, 0);
        check("t6_mem_en", mem_en, 0);

        // Random traffic with occasional lock windows
        rlock = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) rlock = !rlock;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 1),
                 5'($urandom_range(0, 31)), $urandom, rlock);
        end
        for (int i = 0; i < 3; i++) idle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
